alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle sequencer for the 8-bit combinational ALU. It runs 16-bit add, 16-bit shift-left, 16-bit logical-shift-right and 8x8 unsigned multiply as a series of single-byte ALU passes, chaining the carry through `sc_i`/`sc_o`. It sits between the processor control path and the ALU instance. When it is idle, the ALU inputs are parked.

## Interface
- No parameters. The datapath width is fixed at 8 by the ALU.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE.
- `op` in 2: operation select. 0=ADD16, 1=SHL16, 2=LSR16, 3=MUL8.
- `opa` in 16: operand A. MUL8 uses `opa[7:0]` as the multiplicand.
- `opb` in 16: operand B. ADD16 uses it as the addend; MUL8 uses `opb[7:0]` as the multiplier; shifts ignore it.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse; result and flags are valid.
- `result` out 16: registered result, held until the next accepted start.
- `carry` out 1: ADD16 carry-out, or the bit shifted out for shifts. Always 0 for MUL8.
- `zero` out 1: `result == 0`, registered with `result`.
- `alu_cmd` out 4: ALU command.
- `alu_a` out 8: ALU input A.
- `alu_b` out 8: ALU input B.
- `alu_sc_i` out 1: ALU shift/carry in.
- `alu_rslt` in 8: ALU result.
- `alu_sc_o` in 1: ALU shift/carry out.

## Operation
- ALU commands used:
  - 0: add, `{sc_o,rslt} = a+b+sc_i`.
  - 2: shift left, `{sc_o,rslt} = {a,sc_i}`.
  - 4: logical right shift, `{rslt,sc_o} = {sc_i,a}`.
- No other commands are issued.
- On start in IDLE:
  - `opa`, `opb` and `op` are latched into internal registers.
  - The block moves to LO for ADD16/SHL16, HI for LSR16, or M_ADD for MUL8.
- The ALU output of each pass is registered at the end of that pass. Internal carry C captures `alu_sc_o`.
- ADD16:
  - LO pass: cmd 0, a=A[7:0], b=B[7:0], sc_i=0.
  - HI pass: cmd 0, a=A[15:8], b=B[15:8], sc_i=C.
  - `carry` = final C.
- SHL16:
  - LO pass: cmd 2, a=A[7:0], sc_i=0.
  - HI pass: cmd 2, a=A[15:8], sc_i=C.
  - `carry` = old A[15].
- LSR16:
  - HI pass: cmd 4, a=A[15:8], sc_i=0.
  - LO pass: cmd 4, a=A[7:0], sc_i=C.
  - `carry` = old A[0].
- MUL8 (shift-add): P_hi=0, P_lo=multiplier, M=multiplicand, iteration count i=0. Each iteration is exactly three passes:
  - M_ADD: cmd 0, a=P_hi, b=(P_lo[0] ? M : 0), sc_i=0. P_hi←rslt, C←sc_o.
  - M_SH_HI: cmd 4, a=P_hi, sc_i=C. P_hi←rslt, C←sc_o.
  - M_SH_LO: cmd 4, a=P_lo, sc_i=C. P_lo←rslt. i←i+1.
  - After iteration i=7 the block goes to DONE with result={P_hi,P_lo}.
- Latency is data-independent: a zero multiplier bit still performs an add of 0.
- DONE:
  - `done`=1 for one cycle; `result`, `carry` and `zero` are updated.
  - The next state is IDLE.
- In IDLE and DONE the ALU outputs are cmd 0, a=0, b=0, sc_i=0.
- A start asserted in any state other than IDLE is ignored, not queued. A start held high across DONE is accepted in the following IDLE cycle.
- Reset:
  - All state goes to IDLE; `result`=0, `carry`=0, `zero`=1, `busy`=0, `done`=0, ALU outputs parked.
  - This applies mid-operation: the partial result is discarded.

## Timing
- Start is sampled at rising edge k, so the first pass occupies cycle k+1.
- ADD16/SHL16/LSR16: passes in k+1 and k+2; `done` in k+3.
- MUL8: 24 passes in k+1..k+24; `done` in k+25.
- `busy` is high from k+1 through the `done` cycle inclusive.
- The earliest next accept is at edge k+4 (2-pass ops) or k+26 (MUL8).
- ALU outputs are driven from registered state only, so the ALU path is one combinational pass per cycle.
- `result`, `carry` and `zero` change only on the edge that enters DONE.

## Structure
- `alu_seq_pkg` holds:
  - the ALU command constants (ADD=0, SHL=2, LSR=4);
  - the `op` enum;
  - the state enum (IDLE, LO, HI, M_ADD, M_SH_HI, M_SH_LO, DONE).
- The ALU stays external and is connected at the top level or in the bench. No sub-module is instantiated.
- The FSM and operand/iteration registers form one module.

## Test plan
- ADD16 0x00FF+0x0001 → result 0x0100, carry 0, zero 0, `done` exactly 3 cycles after start.
- ADD16 0xFFFF+0x0001 → result 0x0000, carry 1, zero 1.
- SHL16 0x8001 → 0x0002, carry 1. LSR16 0x0101 → 0x0080, carry 1.
- MUL8 0xFF×0xFF → 0xFE01, carry 0, `done` 25 cycles after start. 0x00×0x5A → 0x0000 with zero 1.
- Start pulsed while busy during a MUL8 → ignored, original product returned, exactly one `done`.
- `rst_n` low at pass 10 of a MUL8 → immediate IDLE, `result`=0, `zero`=1, ALU parked. A new ADD16 after release completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants and enums for the ALU sequencer
package alu_seq_pkg;

    // ALU command codes issued by the sequencer
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SHL = 4'd2;
    localparam logic [3:0] ALU_LSR = 4'd4;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'd0,
        OP_SHL16 = 2'd1,
        OP_LSR16 = 2'd2,
        OP_MUL8  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LO      = 3'd1,
        S_HI      = 3'd2,
        S_M_ADD   = 3'd3,
        S_M_SH_HI = 3'd4,
        S_M_SH_LO = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    // ALU command used by the byte passes of a 2-pass operation
    function automatic logic [3:0] pass_cmd(input op_e o);
        case (o)
            OP_SHL16: pass_cmd = ALU_SHL;
            OP_LSR16: pass_cmd = ALU_LSR;
            default:  pass_cmd = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle sequencer driving an external 8-bit ALU
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero,
    output logic [3:0]  alu_cmd,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_sc_i,
    input  logic [7:0]  alu_rslt,
    input  logic        alu_sc_o
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        c_q, c_d;
    logic [7:0]  p_hi_q, p_hi_d;
    logic [7:0]  p_lo_q, p_lo_d;
    logic [2:0]  i_q, i_d;
    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

    // ALU inputs derived only from registered state; parked in IDLE/DONE
    always_comb begin
        alu_cmd  = ALU_ADD;
        alu_a    = 8'd0;
        alu_b    = 8'd0;
        alu_sc_i = 1'b0;
        case (state_q)
            S_LO: begin
                alu_cmd  = pass_cmd(op_q);
                alu_a    = a_q[7:0];
                alu_b    = (op_q == OP_ADD16) ? b_q[7:0] : 8'd0;
                alu_sc_i = (op_q == OP_LSR16) ? c_q : 1'b0;
            end
            S_HI: begin
                alu_cmd  = pass_cmd(op_q);
                alu_a    = a_q[15:8];
                alu_b    = (op_q == OP_ADD16) ? b_q[15:8] : 8'd0;
                alu_sc_i = (op_q == OP_LSR16) ? 1'b0 : c_q;
            end
            S_M_ADD: begin
                alu_cmd  = ALU_ADD;
                alu_a    = p_hi_q;
                alu_b    = p_lo_q[0] ? a_q[7:0] : 8'd0;
            end
            S_M_SH_HI: begin
                alu_cmd  = ALU_LSR;
                alu_a    = p_hi_q;
                alu_sc_i = c_q;
            end
            S_M_SH_LO: begin
                alu_cmd  = ALU_LSR;
                alu_a    = p_lo_q;
                alu_sc_i = c_q;
            end
            default: ;
        endcase
    end

    // Next-state, pass result capture and final result update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        i_d      = i_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op_e'(op);
                    a_d    = opa;
                    b_d    = opb;
                    c_d    = 1'b0;
                    i_d    = 3'd0;
                    p_hi_d = 8'd0;
                    p_lo_d = opb[7:0];
                    case (op_e'(op))
                        OP_MUL8:  state_d = S_M_ADD;
                        OP_LSR16: state_d = S_HI;
                        default:  state_d = S_LO;
                    endcase
                end
            end
            S_LO: begin
                p_lo_d = alu_rslt;
                c_d    = alu_sc_o;
                if (op_q == OP_LSR16) begin
                    result_d = {p_hi_q, alu_rslt};
                    carry_d  = alu_sc_o;
                    zero_d   = ({p_hi_q, alu_rslt} == 16'd0);
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                p_hi_d = alu_rslt;
                c_d    = alu_sc_o;
                if (op_q == OP_LSR16) begin
                    state_d  = S_LO;
                end else begin
                    result_d = {alu_rslt, p_lo_q};
                    carry_d  = alu_sc_o;
                    zero_d   = ({alu_rslt, p_lo_q} == 16'd0);
                    state_d  = S_DONE;
                end
            end
            S_M_ADD: begin
                p_hi_d  = alu_rslt;
                c_d     = alu_sc_o;
                state_d = S_M_SH_HI;
            end
            S_M_SH_HI: begin
                p_hi_d  = alu_rslt;
                c_d     = alu_sc_o;
                state_d = S_M_SH_LO;
            end
            S_M_SH_LO: begin
                p_lo_d = alu_rslt;
                i_d    = i_q + 3'd1;
                if (i_q == 3'd7) begin
                    result_d = {p_hi_q, alu_rslt};
                    carry_d  = 1'b0;
                    zero_d   = ({p_hi_q, alu_rslt} == 16'd0);
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_M_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD16;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            c_q      <= 1'b0;
            p_hi_q   <= 8'd0;
            p_lo_q   <= 8'd0;
            i_q      <= 3'd0;
            result_q <= 16'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            i_q      <= i_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq with a behavioural ALU
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zero;
    logic [3:0]  alu_cmd;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_sc_i;
    logic [7:0]  alu_rslt;
    logic        alu_sc_o;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    int n_done;

    alu_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .alu_cmd  (alu_cmd),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sc_i (alu_sc_i),
        .alu_rslt (alu_rslt),
        .alu_sc_o (alu_sc_o)
    );

    // Reference 8-bit ALU
    always_comb begin
        {alu_sc_o, alu_rslt} = 9'd0;
        case (alu_cmd)
            4'd0: {alu_sc_o, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_i};
            4'd2: {alu_sc_o, alu_rslt} = {alu_a, alu_sc_i};
            4'd4: {alu_rslt, alu_sc_o} = {alu_sc_i, alu_a};
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one start; returns cycles from start edge to done (0 if it never came)
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          output int cycles);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (done !== 1'b1) cycles = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        opa   = 16'd0;
        opb   = 16'd0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 16'h0000);
        check("reset_zero", zero, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_alu_park", {alu_cmd, alu_a, alu_b, alu_sc_i}, 21'd0);
        rst_n = 1'b1;

        // ADD16 0x00FF + 0x0001, also look at the first pass
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 16'h00FF; opb = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("add_pass1_busy", busy, 1'b1);
        check("add_pass1_alu", {alu_cmd, alu_a, alu_b, alu_sc_i}, {4'd0, 8'hFF, 8'h01, 1'b0});
        @(negedge clk);
        check("add_pass2_alu", {alu_cmd, alu_a, alu_b, alu_sc_i}, {4'd0, 8'h00, 8'h00, 1'b1});
        @(negedge clk);
        check("add_done_at_3", done, 1'b1);
        check("add_result", result, 16'h0100);
        check("add_carry", carry, 1'b0);
        check("add_zero", zero, 1'b0);
        @(negedge clk);
        check("add_done_pulse", {done, busy}, 2'b00);
        check("add_result_held", result, 16'h0100);

        run_op(2'd0, 16'hFFFF, 16'h0001, lat);
        check("add_wrap_lat", lat, 3);
        check("add_wrap_result", result, 16'h0000);
        check("add_wrap_carry", carry, 1'b1);
        check("add_wrap_zero", zero, 1'b1);

        run_op(2'd1, 16'h8001, 16'h1234, lat);
        check("shl_lat", lat, 3);
        check("shl_result", result, 16'h0002);
        check("shl_carry", carry, 1'b1);

        run_op(2'd2, 16'h0101, 16'h0000, lat);
        check("lsr_lat", lat, 3);
        check("lsr_result", result, 16'h0080);
        check("lsr_carry", carry, 1'b1);

        run_op(2'd3, 16'h00FF, 16'h00FF, lat);
        check("mul_lat", lat, 25);
        check("mul_ff_result", result, 16'hFE01);
        check("mul_ff_carry", carry, 1'b0);
        check("mul_ff_zero", zero, 1'b0);

        run_op(2'd3, 16'h0000, 16'h005A, lat);
        check("mul_zero_lat", lat, 25);
        check("mul_zero_result", result, 16'h0000);
        check("mul_zero_zero", zero, 1'b1);

        // Start pulsed while a MUL8 is busy must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'd3; opa = 16'h0012; opb = 16'h0034;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 16'h1111; opb = 16'h2222;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) begin
                n_done++;
                check("busy_start_result", result, 16'h03A8);
            end
            @(negedge clk);
        end
        check("busy_start_one_done", n_done, 1);

        // Asynchronous reset during pass 10 of a MUL8
        @(negedge clk);
        start = 1'b1; op = 2'd3; opa = 16'h00FF; opb = 16'h00FF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_zero", zero, 1'b1);
        check("rst_alu_park", {alu_cmd, alu_a, alu_b, alu_sc_i}, 21'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'd0, 16'h1234, 16'h4321, lat);
        check("post_rst_lat", lat, 3);
        check("post_rst_result", result, 16'h5555);
        check("post_rst_carry", carry, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
